// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, NWR synchronous
// write ports, optional same-cycle write-to-read bypass and optional hardwired
// zero entry. The array is cleared by a sequential engine (one entry per cycle)
// so the storage carries no reset and can map onto RAM-style cells.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (starts a full clear)
//   clr          soft clear request, honoured only when ready
//   ra / rdata   packed read addresses / combinational read data, per port
//   we/wa/wd     packed per-port write enable / address / data
//   ready        registered; array valid and accepting writes
//   wr_conflict  registered; two or more effective writes hit one address
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    output logic                ready,
    output logic                wr_conflict
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            ready_q, ready_d;
    logic            wr_conflict_q, wr_conflict_d;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [AW-1:0]   wa_s [NWR];
    logic [XLEN-1:0] wd_s [NWR];
    logic [NWR-1:0]  wr_eff;
    logic            conflict_c;
    logic            clear_en_c;
    logic [AW-1:0]   rd_addr [NRD];
    logic [XLEN-1:0] rd_val  [NRD];

    // Unpack write ports and decide which writes actually land this cycle.
    always_comb begin
        for (int j = 0; j < int'(NWR); j++) begin
            wa_s[j]   = wa[j*AW +: AW];
            wd_s[j]   = wd[j*XLEN +: XLEN];
            wr_eff[j] = (state_q == ST_READY) && !clr && we[j] &&
                        !((ZERO_REG != 0) && (wa_s[j] == '0));
        end
    end

    // Conflict: any two effective writes to the same address.
    always_comb begin
        conflict_c = 1'b0;
        for (int j = 0; j < int'(NWR); j++) begin
            for (int k = j + 1; k < int'(NWR); k++) begin
                if (wr_eff[j] && wr_eff[k] && (wa_s[j] == wa_s[k])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    // Next-state logic for the clear engine and registered status outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ready_d       = ready_q;
        wr_conflict_d = conflict_c;
        clear_en_c    = 1'b0;
        if (rst) begin
            state_d       = ST_CLEAR;
            idx_d         = '0;
            ready_d       = 1'b0;
            wr_conflict_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    clear_en_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state_d = ST_CLEAR;
                        idx_d   = '0;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        idx_q         <= idx_d;
        ready_q       <= ready_d;
        wr_conflict_q <= wr_conflict_d;
    end

    // Storage: no reset; cleared one entry per cycle. Later ports win on ties.
    always_ff @(posedge clk) begin
        if (clear_en_c) begin
            mem_q[idx_q] <= '0;
        end else if (!rst) begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (wr_eff[j]) begin
                    mem_q[wa_s[j]] <= wd_s[j];
                end
            end
        end
    end

    // Read ports: array value, overridden by bypass, then by zero/clear forcing.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            rd_addr[i] = ra[i*AW +: AW];
            rd_val[i]  = mem_q[rd_addr[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < int'(NWR); j++) begin
                    if (wr_eff[j] && (wa_s[j] == rd_addr[i])) begin
                        rd_val[i] = wd_s[j];
                    end
                end
            end
            if ((state_q == ST_CLEAR) || ((ZERO_REG != 0) && (rd_addr[i] == '0))) begin
                rd_val[i] = '0;
            end
            rdata[i*XLEN +: XLEN] = rd_val[i];
        end
    end

    assign ready       = ready_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two instances share clock, reset, clear and read
// addresses: inst 0 is 2R/2W with zero register and bypass, inst 1 is 2R/1W
// with neither. A behavioural model (countdown clear, array memory) predicts
// every read and status output.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [9:0]  ra  = '0;
    logic [1:0]  we  = '0;
    logic [9:0]  wa  = '0;
    logic [63:0] wd  = '0;

    logic [63:0] rd_a, rd_b;
    logic        ready_a, ready_b, conf_a, conf_b;

    regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .ra(ra), .rdata(rd_a),
        .we(we), .wa(wa), .wd(wd), .ready(ready_a), .wr_conflict(conf_a)
    );

    regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .ra(ra), .rdata(rd_b),
        .we(we[0:0]), .wa(wa[4:0]), .wd(wd[31:0]), .ready(ready_b), .wr_conflict(conf_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Reference model state, per instance
    bit          m_clearing [2];
    int          m_left     [2];
    bit          m_conf     [2];
    logic [31:0] m_mem      [2][32];

    function automatic int nwr_of(int inst);
        return (inst == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] exp_rd(int inst, int p);
        int addr;
        bit zr;
        addr = int'(ra[p*5 +: 5]);
        zr   = (inst == 0);
        if (m_clearing[inst]) return 32'h0;
        if (zr && addr == 0) return 32'h0;
        if (inst == 0 && !clr) begin
            for (int j = nwr_of(inst) - 1; j >= 0; j--) begin
                if (we[j] && !(zr && wa[j*5 +: 5] == 5'd0) && int'(wa[j*5 +: 5]) == addr)
                    return wd[j*32 +: 32];
            end
        end
        return m_mem[inst][addr];
    endfunction

    task automatic model_edge();
        for (int inst = 0; inst < 2; inst++) begin
            bit zr;
            zr = (inst == 0);
            if (rst) begin
                m_clearing[inst] = 1'b1;
                m_left[inst]     = 32;
                m_conf[inst]     = 1'b0;
            end else if (m_clearing[inst]) begin
                m_mem[inst][32 - m_left[inst]] = 32'h0;
                m_left[inst]--;
                if (m_left[inst] == 0) m_clearing[inst] = 1'b0;
                m_conf[inst] = 1'b0;
            end else if (clr) begin
                m_clearing[inst] = 1'b1;
                m_left[inst]     = 32;
                m_conf[inst]     = 1'b0;
            end else begin
                int hits [32];
                foreach (hits[a]) hits[a] = 0;
                m_conf[inst] = 1'b0;
                for (int j = 0; j < nwr_of(inst); j++) begin
                    int a;
                    a = int'(wa[j*5 +: 5]);
                    if (we[j] && !(zr && a == 0)) begin
                        m_mem[inst][a] = wd[j*32 +: 32];
                        hits[a]++;
                    end
                end
                foreach (hits[a]) if (hits[a] > 1) m_conf[inst] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: check combinational reads, take the edge, check status.
    task automatic step();
        #2;
        if (started) begin
            chk("rd_a0", rd_a[31:0],  exp_rd(0, 0));
            chk("rd_a1", rd_a[63:32], exp_rd(0, 1));
            chk("rd_b0", rd_b[31:0],  exp_rd(1, 0));
            chk("rd_b1", rd_b[63:32], exp_rd(1, 1));
        end
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
        chk("ready_a", 32'(ready_a), 32'(!m_clearing[0]));
        chk("ready_b", 32'(ready_b), 32'(!m_clearing[1]));
        chk("conf_a",  32'(conf_a),  32'(m_conf[0]));
        chk("conf_b",  32'(conf_b),  32'(m_conf[1]));
    endtask

    task automatic set_rd(input int a0, input int a1);
        ra = {5'(a1), 5'(a0)};
    endtask

    task automatic set_wr(input bit e0, input int a0, input logic [31:0] d0,
                          input bit e1, input int a1, input logic [31:0] d1);
        we = {e1, e0};
        wa = {5'(a1), 5'(a0)};
        wd = {d1, d0};
    endtask

    task automatic run_until_ready(input int expect_n, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_a && n < 200);
        chk(tag, 32'(n), 32'(expect_n));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_clearing[i] = 1'b1;
            m_left[i]     = 32;
            m_conf[i]     = 1'b0;
            foreach (m_mem[i][a]) m_mem[i][a] = 32'h0;
        end

        // Reset held three cycles, then clear runs with reads of x0/x1/x10/x31
        rst = 1'b1;
        set_rd(0, 1);
        repeat (3) step();
        rst = 1'b0;
        set_rd(10, 31);
        run_until_ready(32, "clear_len");
        set_rd(0, 1);  step();
        set_rd(10, 31); step();

        // Write enable
        set_wr(1, 1, 32'h11111111, 0, 0, 32'h0);       step();
        set_wr(0, 4, 32'h44444444, 0, 0, 32'h0);       step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);
        set_rd(1, 4);                                   step();

        // Zero register (inst 0) vs ordinary entry (inst 1)
        set_wr(1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
        set_rd(0, 1);                                   step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);               step();

        // Bypass: same-cycle forward on inst 0, old value on inst 1
        set_rd(5, 5);
        set_wr(1, 5, 32'hCAFEF00D, 0, 0, 32'h0);        step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);               step();

        // Write conflict, highest port wins; zero-register pair is no conflict
        set_rd(7, 7);
        set_wr(1, 7, 32'hAAAAAAAA, 1, 7, 32'hBBBBBBBB); step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);               step();
        step();
        set_wr(1, 0, 32'h01010101, 1, 0, 32'h02020202); step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);               step();

        // Soft clear with a simultaneous write that must be dropped
        for (int a = 1; a <= 3; a++) begin
            set_wr(1, a, 32'h100 * a, 1, a + 8, 32'h5500 + a);
            step();
        end
        clr = 1'b1;
        set_rd(9, 2);
        set_wr(1, 9, 32'h12345678, 0, 0, 32'h0);        step();
        clr = 1'b0;
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);
        run_until_ready(32, "softclr_len");
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            step();
        end

        // Reset on clear cycle 10 restarts the clear; writes ignored meanwhile
        set_wr(1, 3, 32'h33333333, 0, 0, 32'h0);        step();
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);
        clr = 1'b1;                                     step();
        clr = 1'b0;
        repeat (9) step();
        rst = 1'b1;                                     step();
        rst = 1'b0;
        set_rd(3, 3);
        set_wr(1, 3, 32'h77777777, 0, 0, 32'h0);
        run_until_ready(32, "rstmid_len");
        set_wr(0, 0, 32'h0, 0, 0, 32'h0);               step();

        // Randomized traffic with occasional soft clears
        for (int n = 0; n < 400; n++) begin
            ra  = 10'($urandom);
            we  = 2'($urandom);
            wa  = ($urandom_range(0, 1) == 0) ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}
                                               : 10'($urandom);
            wd  = {$urandom, $urandom};
            clr = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 1'b0;
        we  = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
